// File: rtl/cdc_toggle_rx_multi.sv
// Destination-domain receiver for NUM_CH toggle-handshake channels. Captured words are merged
// round-robin into one show-ahead FIFO, tagged with their channel, and acknowledged once stored.
module cdc_toggle_rx_multi #(
    parameter int unsigned           NUM_CH              = 4,
    parameter int unsigned           DATA_WIDTH          = 8,
    parameter int unsigned           SYNC_STAGES         = 2,
    parameter int unsigned           FIFO_DEPTH          = 4,
    parameter logic [DATA_WIDTH-1:0] DST_DATA_IDLE_VALUE = '0,
    localparam int unsigned          CH_W                = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int unsigned          LVL_W               = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                         dst_clk,
    input  logic                         dst_rst_n,
    input  logic [NUM_CH-1:0]            async_toggle,
    input  logic [NUM_CH*DATA_WIDTH-1:0] async_data,
    output logic [NUM_CH-1:0]            async_ack_toggle,
    output logic                         dst_valid,
    input  logic                         dst_ready,
    output logic [DATA_WIDTH-1:0]        dst_data,
    output logic [CH_W-1:0]              dst_channel,
    output logic [LVL_W-1:0]             fifo_level
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

    typedef struct packed {
        logic [CH_W-1:0]       ch;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    (* async_reg = "true" *) logic [NUM_CH-1:0] sync_q [SYNC_STAGES];
    logic [NUM_CH-1:0] sync_d [SYNC_STAGES];
    logic [NUM_CH-1:0] seen_q, seen_d;
    logic [CH_W-1:0]   rr_q, rr_d;
    entry_t            mem_q [FIFO_DEPTH];
    entry_t            mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;

    logic [NUM_CH-1:0]     tog_s;
    logic [NUM_CH-1:0]     pending;
    logic                  grant_found;
    logic [CH_W-1:0]       grant_ch;
    logic [DATA_WIDTH-1:0] grant_data;
    logic                  push;
    logic                  pop;
    entry_t                head;

    assign tog_s   = sync_q[SYNC_STAGES-1];
    assign pending = tog_s ^ seen_q;

    always_comb begin
        grant_found = 1'b0;
        grant_ch    = '0;
        // Wrap-around scan as two passes: channels at or above rr first, then those below it.
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (!grant_found && pending[c] && (CH_W'(c) >= rr_q)) begin
                grant_found = 1'b1;
                grant_ch    = CH_W'(c);
            end
        end
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (!grant_found && pending[c] && (CH_W'(c) < rr_q)) begin
                grant_found = 1'b1;
                grant_ch    = CH_W'(c);
            end
        end
    end

    always_comb begin
        grant_data = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (CH_W'(c) == grant_ch) begin
                grant_data = async_data[c*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Space is judged on the pre-pop level, so a full FIFO never pushes in a pop cycle.
    assign push = grant_found && (level_q < LVL_W'(FIFO_DEPTH));
    assign pop  = (level_q != '0) && dst_ready;

    always_comb begin
        sync_d[0] = async_toggle;
        for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
            sync_d[s] = sync_q[s-1];
        end
        seen_d   = seen_q;
        rr_d     = rr_q;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            mem_d[wr_ptr_q].ch   = grant_ch;
            mem_d[wr_ptr_q].data = grant_data;
            wr_ptr_d             = wr_ptr_q + PTR_W'(1);
            rr_d                 = (grant_ch == CH_W'(NUM_CH - 1)) ? '0 : grant_ch + CH_W'(1);
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                if (CH_W'(c) == grant_ch) begin
                    seen_d[c] = tog_s[c];
                end
            end
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge dst_clk) begin
        if (!dst_rst_n) begin
            for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
            for (int unsigned f = 0; f < FIFO_DEPTH; f++) begin
                mem_q[f] <= '0;
            end
            seen_q   <= '0;
            rr_q     <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            sync_q   <= sync_d;
            mem_q    <= mem_d;
            seen_q   <= seen_d;
            rr_q     <= rr_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    assign head             = mem_q[rd_ptr_q];
    assign dst_valid        = (level_q != '0);
    assign dst_data         = dst_valid ? head.data : DST_DATA_IDLE_VALUE;
    assign dst_channel      = dst_valid ? head.ch : '0;
    assign fifo_level       = level_q;
    assign async_ack_toggle = seen_q;

endmodule

// File: tb/tb_cdc_toggle_rx_multi.sv
// Bench for a 5-channel, 4-deep cdc_toggle_rx_multi: vector table, hand-written corner sequences
// and a randomized soak, all cross-checked each cycle against a queue-based reference model.
module tb_cdc_toggle_rx_multi;

    localparam int NCH   = 5;
    localparam int DW    = 8;
    localparam int SYNC  = 2;
    localparam int DEPTH = 4;

    logic            dst_clk = 1'b0;
    logic            dst_rst_n;
    logic [NCH-1:0]  src_tog;
    logic [DW-1:0]   src_data [NCH];
    logic [NCH*DW-1:0] async_data;
    logic [NCH-1:0]  async_ack_toggle;
    logic            dst_valid;
    logic            dst_ready;
    logic [DW-1:0]   dst_data;
    logic [2:0]      dst_channel;
    logic [2:0]      fifo_level;

    always #5 dst_clk = ~dst_clk;

    always_comb begin
        for (int c = 0; c < NCH; c++) async_data[c*DW +: DW] = src_data[c];
    end

    cdc_toggle_rx_multi #(
        .NUM_CH(NCH),
        .DATA_WIDTH(DW),
        .SYNC_STAGES(SYNC),
        .FIFO_DEPTH(DEPTH),
        .DST_DATA_IDLE_VALUE(8'h00)
    ) dut (
        .dst_clk(dst_clk),
        .dst_rst_n(dst_rst_n),
        .async_toggle(src_tog),
        .async_data(async_data),
        .async_ack_toggle(async_ack_toggle),
        .dst_valid(dst_valid),
        .dst_ready(dst_ready),
        .dst_data(dst_data),
        .dst_channel(dst_channel),
        .fifo_level(fifo_level)
    );

    int n_cmp = 0;
    int n_bad = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endfunction

    // Reference model: FIFO as a queue, synchroniser as "toggle value SYNC edges ago".
    typedef struct packed {
        logic [2:0]    ch;
        logic [DW-1:0] data;
    } ent_t;

    ent_t           mq[$];
    logic [NCH-1:0] hist[$];
    logic [NCH-1:0] m_seen;
    int             m_rr;

    function automatic void model_edge();
        logic [NCH-1:0] synced;
        int gnt;
        ent_t e;
        if (!dst_rst_n) begin
            mq.delete();
            hist.delete();
            for (int k = 0; k < SYNC; k++) hist.push_back('0);
            m_seen = '0;
            m_rr   = 0;
            return;
        end
        synced = hist[SYNC-1];
        gnt = -1;
        if (mq.size() < DEPTH) begin
            for (int k = 0; k < NCH; k++) begin
                int c;
                c = (m_rr + k) % NCH;
                if (gnt < 0 && synced[c] != m_seen[c]) gnt = c;
            end
        end
        if (mq.size() != 0 && dst_ready) void'(mq.pop_front());
        if (gnt >= 0) begin
            e.ch   = 3'(gnt);
            e.data = src_data[gnt];
            mq.push_back(e);
            m_seen[gnt] = synced[gnt];
            m_rr = (gnt + 1) % NCH;
        end
        hist.push_front(src_tog);
        void'(hist.pop_back());
    endfunction

    function automatic void check_model(string tag);
        logic ev;
        ev = (mq.size() != 0);
        chk({tag, ".m_valid"}, 32'(dst_valid), 32'(ev));
        chk({tag, ".m_level"}, 32'(fifo_level), 32'(mq.size()));
        chk({tag, ".m_ack"},   32'(async_ack_toggle), 32'(m_seen));
        chk({tag, ".m_ch"},    32'(dst_channel), ev ? 32'(mq[0].ch) : 32'd0);
        chk({tag, ".m_data"},  32'(dst_data), ev ? 32'(mq[0].data) : 32'd0);
    endfunction

    // Soak scoreboard: per-channel queues of words the source model has sent.
    logic [DW-1:0]  expq [NCH][$];
    logic [NCH-1:0] ack_s1, ack_s2;
    int             sent, delivered;
    bit             sb_on;

    function automatic void sb_pop(logic [2:0] ch, logic [DW-1:0] d);
        logic [DW-1:0] w;
        if (32'(ch) >= NCH || expq[ch].size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL sb_extra: got word %0h on ch %0d, required an outstanding word", d, ch);
        end else begin
            w = expq[ch].pop_front();
            chk($sformatf("sb_word.ch%0d", ch), 32'(d), 32'(w));
            delivered++;
        end
    endfunction

    function automatic int outstanding();
        int n;
        n = 0;
        for (int c = 0; c < NCH; c++) n += expq[c].size();
        return n;
    endfunction

    task automatic step(string tag);
        #3;
        if (sb_on && dst_valid && dst_ready) sb_pop(dst_channel, dst_data);
        @(posedge dst_clk);
        model_edge();
        #1;
        check_model(tag);
    endtask

    task automatic expect_out(string tag, logic v, logic [NCH-1:0] ack, int lvl, int ch, logic [DW-1:0] d);
        chk({tag, ".valid"}, 32'(dst_valid), 32'(v));
        chk({tag, ".ack"},   32'(async_ack_toggle), 32'(ack));
        chk({tag, ".level"}, 32'(fifo_level), 32'(lvl));
        chk({tag, ".ch"},    32'(dst_channel), 32'(ch));
        chk({tag, ".data"},  32'(dst_data), 32'(d));
    endtask

    task automatic flip(logic [NCH-1:0] mask, logic [DW-1:0] base);
        for (int c = 0; c < NCH; c++) begin
            if (mask[c]) begin
                src_data[c] = base + 8'(c);
                src_tog[c]  = ~src_tog[c];
            end
        end
    endtask

    typedef struct {
        logic [NCH-1:0] flip;
        logic [DW-1:0]  base;
        logic           ready;
        logic           ev;
        logic [NCH-1:0] eack;
        int             elvl;
        int             ech;
        logic [DW-1:0]  edata;
    } vec_t;

    function automatic vec_t mk(logic [NCH-1:0] f, logic [DW-1:0] b, logic r,
                                logic v, logic [NCH-1:0] a, int l, int ch, logic [DW-1:0] d);
        vec_t t;
        t.flip = f; t.base = b; t.ready = r;
        t.ev = v; t.eack = a; t.elvl = l; t.ech = ch; t.edata = d;
        return t;
    endfunction

    vec_t tbl[$];

    initial begin
        for (int k = 0; k < SYNC; k++) hist.push_back('0);
        m_seen = '0;
        m_rr = 0;
        sb_on = 0;
        sent = 0;
        delivered = 0;
        ack_s1 = '0;
        ack_s2 = '0;
        dst_rst_n = 1'b0;
        dst_ready = 1'b0;
        src_tog = '0;
        for (int c = 0; c < NCH; c++) src_data[c] = '0;

        // Round-robin from rr=0, then from rr=2 after a lone ch1 grant (ch4 idle throughout).
        tbl.push_back(mk(5'h0F, 8'h10, 0, 0, 5'h00, 0, 0, 8'h00));
        tbl.push_back(mk(5'h00, 8'h00, 0, 0, 5'h00, 0, 0, 8'h00));
        tbl.push_back(mk(5'h00, 8'h00, 0, 1, 5'h01, 1, 0, 8'h10));
        tbl.push_back(mk(5'h00, 8'h00, 0, 1, 5'h03, 2, 0, 8'h10));
        tbl.push_back(mk(5'h00, 8'h00, 0, 1, 5'h07, 3, 0, 8'h10));
        tbl.push_back(mk(5'h00, 8'h00, 0, 1, 5'h0F, 4, 0, 8'h10));
        tbl.push_back(mk(5'h00, 8'h00, 1, 1, 5'h0F, 3, 1, 8'h11));
        tbl.push_back(mk(5'h00, 8'h00, 1, 1, 5'h0F, 2, 2, 8'h12));
        tbl.push_back(mk(5'h00, 8'h00, 1, 1, 5'h0F, 1, 3, 8'h13));
        tbl.push_back(mk(5'h00, 8'h00, 1, 0, 5'h0F, 0, 0, 8'h00));
        tbl.push_back(mk(5'h02, 8'h20, 0, 0, 5'h0F, 0, 0, 8'h00));
        tbl.push_back(mk(5'h00, 8'h00, 0, 0, 5'h0F, 0, 0, 8'h00));
        tbl.push_back(mk(5'h00, 8'h00, 0, 1, 5'h0D, 1, 1, 8'h21));
        tbl.push_back(mk(5'h00, 8'h00, 1, 0, 5'h0D, 0, 0, 8'h00));
        tbl.push_back(mk(5'h0F, 8'h30, 0, 0, 5'h0D, 0, 0, 8'h00));
        tbl.push_back(mk(5'h00, 8'h00, 0, 0, 5'h0D, 0, 0, 8'h00));
        tbl.push_back(mk(5'h00, 8'h00, 0, 1, 5'h09, 1, 2, 8'h32));
        tbl.push_back(mk(5'h00, 8'h00, 0, 1, 5'h01, 2, 2, 8'h32));
        tbl.push_back(mk(5'h00, 8'h00, 0, 1, 5'h00, 3, 2, 8'h32));
        tbl.push_back(mk(5'h00, 8'h00, 0, 1, 5'h02, 4, 2, 8'h32));
        tbl.push_back(mk(5'h00, 8'h00, 1, 1, 5'h02, 3, 3, 8'h33));
        tbl.push_back(mk(5'h00, 8'h00, 1, 1, 5'h02, 2, 0, 8'h30));
        tbl.push_back(mk(5'h00, 8'h00, 1, 1, 5'h02, 1, 1, 8'h31));
        tbl.push_back(mk(5'h00, 8'h00, 1, 0, 5'h02, 0, 0, 8'h00));

        step("rst");
        step("rst");
        expect_out("reset", 0, 5'h00, 0, 0, 8'h00);
        dst_rst_n = 1'b1;

        // Single word: toggle flips before E0, word and ack appear after E0+2, popped at E0+3.
        dst_ready = 1'b1;
        src_data[0] = 8'hA5;
        src_tog[0] = 1'b1;
        step("sw");
        step("sw");
        expect_out("sw.e1", 0, 5'h00, 0, 0, 8'h00);
        step("sw");
        expect_out("sw.e2", 1, 5'h01, 1, 0, 8'hA5);
        step("sw");
        expect_out("sw.e3", 0, 5'h01, 0, 0, 8'h00);

        dst_rst_n = 1'b0;
        src_tog = '0;
        dst_ready = 1'b0;
        step("rst2");
        dst_rst_n = 1'b1;

        foreach (tbl[i]) begin
            flip(tbl[i].flip, tbl[i].base);
            dst_ready = tbl[i].ready;
            step($sformatf("tbl%0d", i));
            expect_out($sformatf("tbl%0d", i), tbl[i].ev, tbl[i].eack, tbl[i].elvl, tbl[i].ech, tbl[i].edata);
        end

        // Backpressure: five events into four slots; the fifth (ch1) waits for space.
        dst_ready = 1'b0;
        flip(5'h1F, 8'h40);
        step("bp");
        step("bp");
        expect_out("bp.e1", 0, 5'h02, 0, 0, 8'h00);
        step("bp");
        expect_out("bp.e2", 1, 5'h06, 1, 2, 8'h42);
        step("bp");
        expect_out("bp.e3", 1, 5'h0E, 2, 2, 8'h42);
        step("bp");
        expect_out("bp.e4", 1, 5'h1E, 3, 2, 8'h42);
        step("bp");
        expect_out("bp.full", 1, 5'h1F, 4, 2, 8'h42);
        step("bp");
        expect_out("bp.hold", 1, 5'h1F, 4, 2, 8'h42);
        dst_ready = 1'b1;
        step("bp");
        expect_out("bp.pulse", 1, 5'h1F, 3, 3, 8'h43);
        dst_ready = 1'b0;
        step("bp");
        expect_out("bp.fifth", 1, 5'h1D, 4, 3, 8'h43);

        // Simultaneous push and pop at level 2.
        dst_ready = 1'b1;
        step("pp");
        step("pp");
        expect_out("pp.lvl2", 1, 5'h1D, 2, 0, 8'h40);
        dst_ready = 1'b0;
        flip(5'h0C, 8'h50);
        step("pp");
        step("pp");
        dst_ready = 1'b1;
        step("pp");
        expect_out("pp.both1", 1, 5'h19, 2, 1, 8'h41);
        step("pp");
        expect_out("pp.both2", 1, 5'h11, 2, 2, 8'h52);
        step("pp");
        expect_out("pp.pop3", 1, 5'h11, 1, 3, 8'h53);
        step("pp");
        expect_out("pp.empty", 0, 5'h11, 0, 0, 8'h00);

        // Reset with three words queued.
        dst_ready = 1'b0;
        flip(5'h07, 8'h60);
        for (int k = 0; k < 5; k++) step("mr");
        chk("mr.level3", 32'(fifo_level), 32'd3);
        dst_rst_n = 1'b0;
        src_tog = '0;
        step("mr");
        expect_out("mr.rst", 0, 5'h00, 0, 0, 8'h00);
        dst_rst_n = 1'b1;
        dst_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step("mr");
            expect_out($sformatf("mr.after%0d", k), 0, 5'h00, 0, 0, 8'h00);
        end

        // Soak: sources with their own ack synchroniser, random consumer, alternating stall phases.
        dst_rst_n = 1'b0;
        dst_ready = 1'b0;
        step("soak.rst");
        dst_rst_n = 1'b1;
        sb_on = 1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            ack_s2 = ack_s1;
            ack_s1 = async_ack_toggle;
            for (int c = 0; c < NCH; c++) begin
                if (src_tog[c] == ack_s2[c] && $urandom_range(0, 2) == 0) begin
                    logic [DW-1:0] d;
                    d = 8'($urandom);
                    src_data[c] = d;
                    src_tog[c] = ~src_tog[c];
                    expq[c].push_back(d);
                    sent++;
                end
            end
            if ((cyc / 400) % 2 == 0) dst_ready = ($urandom_range(0, 3) != 0);
            else                      dst_ready = ($urandom_range(0, 3) == 0);
            step("soak");
        end

        dst_ready = 1'b1;
        for (int k = 0; k < 200 && outstanding() > 0; k++) step("drain");
        chk("drain.outstanding", 32'(outstanding()), 32'd0);
        chk("drain.count", 32'(delivered), 32'(sent));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
